// File: rtl/y2_replay_buffer.sv
// -----------------------------------------------------------------------------
// y2_replay_buffer
//
// Ping-pong store for normalised activations (y2). The forward path writes one
// token (hidden_num elements, BEATS = hidden_num/N beats of N lanes) into the
// current write bank. A start pulse from the backward first stage replays the
// oldest stored token as a contiguous y2/y2_valid/y2_last stream with no
// backpressure. Writing the next token overlaps with replaying the previous one.
// Element bit patterns (fp16) are stored and replayed verbatim.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset (all outputs 0 while high)
//   wr_data    in   N*bitwidth forward beat, lane k = bits [k*bitwidth +: bitwidth]
//   wr_valid   in   wr_data valid
//   wr_last    in   final beat of a token
//   wr_ready   out  write bank can accept a beat (bank EMPTY or FILLING)
//   start      in   replay request pulse (dz2start)
//   y2         out  replayed beat, zero when y2_valid=0
//   y2_valid   out  replay beat valid
//   y2_last    out  final replay beat of the token
//   full_cnt   out  number of banks FULL or READING (0..2)
//   len_err    out  sticky: wr_last position differed from beat BEATS-1
//   start_err  out  sticky: start while a request was pending or streaming
// -----------------------------------------------------------------------------
module y2_replay_buffer #(
  parameter int bitwidth   = 16,
  parameter int N          = 8,
  parameter int hidden_num = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N*bitwidth-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic                  start,
  output logic [N*bitwidth-1:0] y2,
  output logic                  y2_valid,
  output logic                  y2_last,
  output logic [1:0]            full_cnt,
  output logic                  len_err,
  output logic                  start_err
);

  localparam int BEATS  = hidden_num / N;
  localparam int W      = N * bitwidth;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ADDR_W = $clog2(2 * BEATS);

  generate
    if ((hidden_num % N) != 0 || hidden_num < N) begin : g_bad_cfg
      $error("y2_replay_buffer: hidden_num must be a non-zero multiple of N");
    end
  endgenerate

  typedef enum logic [1:0] {
    B_EMPTY   = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2,
    B_READING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_WAIT   = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

  // Storage: bank b occupies words [b*BEATS, b*BEATS+BEATS-1]. No reset on data.
  logic [W-1:0] mem_q [0:2*BEATS-1];

  // Control state
  bank_state_t bank_q [0:1];
  bank_state_t bank_d [0:1];
  rd_state_t   rd_state_q, rd_state_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic [1:0]        full_cnt_q, full_cnt_d;
  logic              len_err_q, len_err_d;
  logic              start_err_q, start_err_d;

  // Read pipeline stage 1 (registered RAM output with its valid/last)
  logic              vld_p1_q, vld_p1_d;
  logic              last_p1_q, last_p1_d;
  logic [W-1:0]      rd_data_p1_q;

  // Combinational helpers
  logic              wr_ready_int;
  logic              wr_accept;
  logic              wr_at_end;
  logic              wr_close;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_full;
  logic              rd_issue;
  logic              rd_at_end;
  logic [ADDR_W-1:0] rd_addr;

  // ---------------------------------------------------------------------------
  // Write side decode
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ready_int = (bank_q[wr_ptr_q] == B_EMPTY) || (bank_q[wr_ptr_q] == B_FILLING);
    wr_accept    = wr_valid & wr_ready_int & ~rst;
    wr_at_end    = (wcnt_q == CNT_W'(BEATS - 1));
    wr_close     = wr_accept & (wr_last | wr_at_end);
    wr_addr      = (wr_ptr_q ? ADDR_W'(BEATS) : ADDR_W'(0)) + ADDR_W'(wcnt_q);
  end

  // ---------------------------------------------------------------------------
  // Read side decode: one RAM read issued per STREAM cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_full   = (bank_q[rd_ptr_q] == B_FULL);
    rd_issue  = (rd_state_q == RD_STREAM);
    rd_at_end = (rcnt_q == CNT_W'(BEATS - 1));
    rd_addr   = (rd_ptr_q ? ADDR_W'(BEATS) : ADDR_W'(0)) + ADDR_W'(rcnt_q);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: bank states, pointers, counters, read FSM, sticky errors
  // ---------------------------------------------------------------------------
  always_comb begin
    bank_d      = bank_q;
    rd_state_d  = rd_state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    len_err_d   = len_err_q;
    start_err_d = start_err_q;
    vld_p1_d    = rd_issue;
    last_p1_d   = rd_issue & rd_at_end;
    full_cnt_d  = 2'd0;

    // Write bank: a short or long token still closes the bank so the stream
    // side never deadlocks; the mismatch is only flagged.
    if (wr_accept) begin
      if (wr_close) begin
        bank_d[wr_ptr_q] = B_FULL;
        wcnt_d           = '0;
        wr_ptr_d         = ~wr_ptr_q;
        if (wr_last != wr_at_end) begin
          len_err_d = 1'b1;
        end
      end else begin
        bank_d[wr_ptr_q] = B_FILLING;
        wcnt_d           = wcnt_q + CNT_W'(1);
      end
    end

    // Read FSM. A request that arrives before its bank is FULL parks in WAIT
    // rather than being lost; a second request is never queued.
    unique case (rd_state_q)
      RD_IDLE: begin
        if (start) begin
          if (rd_full) begin
            rd_state_d       = RD_STREAM;
            rcnt_d           = '0;
            bank_d[rd_ptr_q] = B_READING;
          end else begin
            rd_state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (start) begin
          start_err_d = 1'b1;
        end
        if (rd_full) begin
          rd_state_d       = RD_STREAM;
          rcnt_d           = '0;
          bank_d[rd_ptr_q] = B_READING;
        end
      end
      RD_STREAM: begin
        if (start) begin
          start_err_d = 1'b1;
        end
        if (rd_at_end) begin
          rd_state_d = RD_IDLE;
          rcnt_d     = '0;
        end else begin
          rcnt_d = rcnt_q + CNT_W'(1);
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase

    // Bank is released once its last beat has left the output register. The
    // FSM cannot be entering STREAM on this same bank in this cycle because it
    // was streaming from it one cycle earlier.
    if (last_p1_q) begin
      bank_d[rd_ptr_q] = B_EMPTY;
      rd_ptr_d         = ~rd_ptr_q;
    end

    // Counted from the next bank state so full_cnt stays coherent with wr_ready.
    for (int b = 0; b < 2; b++) begin
      if (bank_d[b] == B_FULL || bank_d[b] == B_READING) begin
        full_cnt_d = full_cnt_d + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0]   <= B_EMPTY;
      bank_q[1]   <= B_EMPTY;
      rd_state_q  <= RD_IDLE;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      full_cnt_q  <= 2'd0;
      len_err_q   <= 1'b0;
      start_err_q <= 1'b0;
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      rd_state_q  <= rd_state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      full_cnt_q  <= full_cnt_d;
      len_err_q   <= len_err_d;
      start_err_q <= start_err_d;
      vld_p1_q    <= vld_p1_d;
      last_p1_q   <= last_p1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: one write port, one registered read port (stage p0 -> p1)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_issue) begin
      rd_data_p1_q <= mem_q[rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: forced to zero while rst is high, data zeroed when not valid
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ready  = wr_ready_int & ~rst;
    y2_valid  = vld_p1_q & ~rst;
    y2_last   = last_p1_q & ~rst;
    y2        = (vld_p1_q & ~rst) ? rd_data_p1_q : '0;
    full_cnt  = rst ? 2'd0 : full_cnt_q;
    len_err   = len_err_q & ~rst;
    start_err = start_err_q & ~rst;
  end

endmodule

// File: tb/tb_y2_replay_buffer.sv
module tb_y2_replay_buffer;

  localparam int BW = 16;
  localparam int NL = 8;
  localparam int HN = 16;
  localparam int W  = NL * BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  wr_data;
  logic          wr_valid;
  logic          wr_last;
  logic          wr_ready;
  logic          start;
  logic [W-1:0]  y2;
  logic          y2_valid;
  logic          y2_last;
  logic [1:0]    full_cnt;
  logic          len_err;
  logic          start_err;

  int n_checks = 0;
  int n_errors = 0;

  y2_replay_buffer #(.bitwidth(BW), .N(NL), .hidden_num(HN)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_last   (wr_last),
    .wr_ready  (wr_ready),
    .start     (start),
    .y2        (y2),
    .y2_valid  (y2_valid),
    .y2_last   (y2_last),
    .full_cnt  (full_cnt),
    .len_err   (len_err),
    .start_err (start_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [BW-1:0] v);
    return {NL{v}};
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [BW-1:0] v, input logic last);
    wr_valid = 1'b1;
    wr_data  = rep(v);
    wr_last  = last;
  endtask

  task automatic clr_beat();
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_last  = 1'b0;
  endtask

  // Two-beat token, back-to-back, last beat flagged.
  task automatic write_token(input logic [BW-1:0] a, input logic [BW-1:0] b);
    set_beat(a, 1'b0);
    tick();
    set_beat(b, 1'b1);
    tick();
    clr_beat();
  endtask

  // Start pulse in cycle t; returns in cycle t+1.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input logic [BW-1:0] v, input logic last);
    chk({tag, "_vld"}, W'(y2_valid), W'(1'b1));
    chk({tag, "_dat"}, y2, rep(v));
    chk({tag, "_lst"}, W'(y2_last), W'(last));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, W'(y2_valid), W'(1'b0));
    chk({tag, "_dat"}, y2, '0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    clr_beat();

    // Reset: all outputs low while rst is held
    tick();
    tick();
    chk("rst_wr_ready", W'(wr_ready), W'(1'b0));
    chk("rst_y2_valid", W'(y2_valid), W'(1'b0));
    chk("rst_full_cnt", W'(full_cnt), W'(2'd0));
    chk("rst_len_err", W'(len_err), W'(1'b0));
    chk("rst_start_err", W'(start_err), W'(1'b0));
    rst = 1'b0;
    tick();
    chk("post_rst_wr_ready", W'(wr_ready), W'(1'b1));

    // T1 basic: token into bank 0, start 3 cycles later
    write_token(16'h3C00, 16'h4000);
    chk("t1_full_cnt", W'(full_cnt), W'(2'd1));
    chk("t1_wr_ready", W'(wr_ready), W'(1'b1));
    tick();
    tick();
    pulse_start();
    chk_idle("t1_t1");
    tick();
    chk_beat("t1_b0", 16'h3C00, 1'b0);
    tick();
    chk_beat("t1_b1", 16'h4000, 1'b1);
    tick();
    chk_idle("t1_end");
    chk("t1_full_cnt_end", W'(full_cnt), W'(2'd0));

    // T2 ping-pong: A into bank 1, B into bank 0, writer stalls on bank 1
    set_beat(16'h1111, 1'b0); tick();
    set_beat(16'h2222, 1'b1); tick();
    set_beat(16'h3333, 1'b0); tick();
    set_beat(16'h4444, 1'b1); tick();
    clr_beat();
    chk("t2_full_cnt2", W'(full_cnt), W'(2'd2));
    chk("t2_wr_ready0", W'(wr_ready), W'(1'b0));
    // Beat offered while not ready is dropped silently
    set_beat(16'hDEAD, 1'b1);
    tick();
    clr_beat();
    chk("t2_drop_len_err", W'(len_err), W'(1'b0));
    chk("t2_drop_full_cnt", W'(full_cnt), W'(2'd2));
    pulse_start();
    chk_idle("t2a_t1");
    tick();
    chk_beat("t2a_b0", 16'h1111, 1'b0);
    tick();
    chk_beat("t2a_b1", 16'h2222, 1'b1);
    chk("t2a_wr_ready_at_last", W'(wr_ready), W'(1'b0));
    tick();
    chk("t2a_wr_ready_after", W'(wr_ready), W'(1'b1));
    chk("t2a_full_cnt", W'(full_cnt), W'(2'd1));
    chk_idle("t2a_end");
    pulse_start();
    tick();
    chk_beat("t2b_b0", 16'h3333, 1'b0);
    tick();
    chk_beat("t2b_b1", 16'h4444, 1'b1);
    tick();
    chk_idle("t2b_end");
    chk("t2b_full_cnt", W'(full_cnt), W'(2'd0));

    // T3 early start: start coincides with the last beat of C (bank 1)
    set_beat(16'h5555, 1'b0);
    tick();
    set_beat(16'h6666, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    clr_beat();
    chk_idle("t3_t1");
    tick();
    chk_idle("t3_t2");
    tick();
    chk_beat("t3_b0", 16'h5555, 1'b0);
    tick();
    chk_beat("t3_b1", 16'h6666, 1'b1);
    chk("t3_start_err", W'(start_err), W'(1'b0));
    tick();
    chk_idle("t3_end");

    // T4 errors: short token into bank 0, then a second start during STREAM
    set_beat(16'h7777, 1'b1);
    tick();
    clr_beat();
    chk("t4_len_err", W'(len_err), W'(1'b1));
    chk("t4_full_cnt", W'(full_cnt), W'(2'd1));
    pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_beat("t4_b0", 16'h7777, 1'b0);
    tick();
    // Unwritten entry replays stale data from token B
    chk_beat("t4_b1_stale", 16'h4444, 1'b1);
    tick();
    chk_idle("t4_end");
    chk("t4_start_err", W'(start_err), W'(1'b1));
    tick();
    chk_idle("t4_no_extra");
    chk("t4_len_err_sticky", W'(len_err), W'(1'b1));

    // T5 reset mid-stream: D into bank 1, reset on the beat-0 cycle
    write_token(16'h8888, 16'h9999);
    pulse_start();
    tick();
    chk_beat("t5_b0", 16'h8888, 1'b0);
    rst = 1'b1;
    tick();
    chk_idle("t5_rst");
    chk("t5_rst_last", W'(y2_last), W'(1'b0));
    chk("t5_rst_wr_ready", W'(wr_ready), W'(1'b0));
    rst = 1'b0;
    tick();
    chk("t5_full_cnt", W'(full_cnt), W'(2'd0));
    chk("t5_len_err", W'(len_err), W'(1'b0));
    chk("t5_start_err", W'(start_err), W'(1'b0));
    chk("t5_wr_ready", W'(wr_ready), W'(1'b1));
    // Start with nothing stored: request waits, no output
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk_idle("t5_wait");
      tick();
    end
    // Filling bank 0 releases the pending request
    write_token(16'hAAAA, 16'hBBBB);
    chk_idle("t5_e_t1");
    tick();
    chk_idle("t5_e_t2");
    tick();
    chk_beat("t5_e_b0", 16'hAAAA, 1'b0);
    tick();
    chk_beat("t5_e_b1", 16'hBBBB, 1'b1);
    chk("t5_e_start_err", W'(start_err), W'(1'b0));
    tick();
    chk_idle("t5_e_end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
